// File: rtl/bp_pht_update_ctrl.sv
// Write-port owner for a 2-bit saturating-counter PHT: init sweep, then queued RMW updates.
// Optional `BP_UPD_BYPASS_EN: apply an update in its handshake cycle when RUN and the FIFO is empty.
module bp_pht_update_ctrl #(
  parameter int unsigned IDX_W      = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_req,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [IDX_W-1:0]              upd_idx,
  input  logic                          upd_taken,
  input  logic [1:0]                    pht_rdata,
  output logic                          pht_we,
  output logic [IDX_W-1:0]              pht_widx,
  output logic [1:0]                    pht_wdata,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   pend_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_sweep_idx, w_sweep_nxt;
  logic [IDX_W:0]    r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr, r_rptr;

  logic              w_full, w_empty, w_push, w_pop, w_bypass;
  logic [IDX_W-1:0]  w_head_idx;
  logic              w_head_taken;

  function automatic logic [1:0] sat_upd(input logic [1:0] v, input logic taken);
    if (taken) return (v == 2'b11) ? v : v + 2'b01;
    else       return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  // The extra wrap bit distinguishes full from empty when the low pointer bits match.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign pend_cnt = r_wptr - r_rptr;

  assign {w_head_idx, w_head_taken} = r_fifo[r_rptr[PTR_W-1:0]];

  assign w_pop = (r_state == ST_RUN) && !w_empty && !init_req;

`ifdef BP_UPD_BYPASS_EN
  assign w_bypass = (r_state == ST_RUN) && w_empty && upd_valid && !init_req;
`else
  assign w_bypass = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign upd_ready = !w_full || w_pop;
  assign w_push    = upd_valid && upd_ready && !init_req && !w_bypass;
  assign init_done = (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    unique case (r_state)
      ST_INIT: begin
        if (init_req) begin
          w_sweep_nxt = '0;
        end else if (r_sweep_idx == '1) begin
          w_state_nxt = ST_RUN;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_idx + 1'b1;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          w_state_nxt = ST_INIT;
          w_sweep_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_sweep_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_widx  = r_sweep_idx;
    pht_wdata = INIT_VAL;
    if (rst) begin
      if (r_state == ST_INIT) begin
        pht_we = 1'b1;
      end else if (w_pop) begin
        pht_we    = 1'b1;
        pht_widx  = w_head_idx;
        pht_wdata = sat_upd(pht_rdata, w_head_taken);
      end else if (w_bypass) begin
        pht_we    = 1'b1;
        pht_widx  = upd_idx;
        pht_wdata = sat_upd(pht_rdata, upd_taken);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (init_req) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= {upd_idx, upd_taken};
  end

endmodule
